// File: rtl/memresp_wb.sv
// memresp_wb: Wishbone B4 pipelined on-chip memory with a fixed accept-to-response latency.
// Requests outside the address region return an error. Define MEMRESP_WRPROT_EN to make the region read-only.
module memresp_wb #(
    parameter int                       ADDRESS_WIDTH = 30,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_ADDR      = 30'h4000000,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_MASK      = 30'h4000000,
    parameter int                       LGMEMSZ       = 12,
    parameter int                       LATENCY       = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]  i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                      o_wb_stall,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic [DATA_WIDTH-1:0]     o_wb_data
);
    localparam int SELW  = DATA_WIDTH / 8;
    localparam int MEMSZ = 1 << LGMEMSZ;
`ifdef MEMRESP_WRPROT_EN
    localparam logic WRPROT = 1'b1;
`else
    localparam logic WRPROT = 1'b0;
`endif

    logic                  accept_s;
    logic                  hit_s;
    logic                  wr_en_s;
    logic                  ack_in_s;
    logic                  rd_in_s;
    logic                  flush_s;
    logic [LGMEMSZ-1:0]    idx_s;
    logic [LATENCY-1:0]    ack_q, ack_d;
    logic [LATENCY-1:0]    err_q, err_d;
    logic [LATENCY-1:0]    rd_q, rd_d;
    logic                  err_state_q, err_state_d;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic [DATA_WIDTH-1:0] mem_q [MEMSZ];

    assign o_wb_ack   = ack_q[LATENCY-1];
    assign o_wb_err   = err_q[LATENCY-1];
    assign o_wb_stall = err_state_q | o_wb_err;
    assign o_wb_data  = dat_q[LATENCY-1];

    // Request decode: acceptance, region hit and the kind of response it will earn.
    always_comb begin
        hit_s    = ((i_wb_addr & MEM_MASK) == MEM_ADDR);
        idx_s    = i_wb_addr[LGMEMSZ-1:0];
        accept_s = i_wb_cyc & i_wb_stb & ~o_wb_stall;
        ack_in_s = hit_s & ~(i_wb_we & WRPROT);
        rd_in_s  = ~i_wb_we;
        wr_en_s  = accept_s & hit_s & i_wb_we & ~WRPROT & ~i_reset;
        // Dropping cyc, or an error being shown, discards everything still in flight.
        flush_s  = ~i_wb_cyc | o_wb_stall;
    end

    // Response pipeline next state: one slot per cycle of latency, oldest at the top.
    always_comb begin
        ack_d       = '0;
        err_d       = '0;
        rd_d        = '0;
        err_state_d = i_wb_cyc & o_wb_stall;
        if (flush_s) begin
            ack_d = '0;
            err_d = '0;
            rd_d  = '0;
        end else begin
            ack_d    = ack_q << 1'b1;
            err_d    = err_q << 1'b1;
            rd_d     = rd_q << 1'b1;
            ack_d[0] = accept_s & ack_in_s;
            err_d[0] = accept_s & ~ack_in_s;
            rd_d[0]  = accept_s & rd_in_s;
        end
    end

    // Response pipeline and error-state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q       <= '0;
            err_q       <= '0;
            rd_q        <= '0;
            err_state_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            err_state_q <= err_state_d;
        end
    end

    // Read data captured at acceptance and carried alongside read acks only, so the
    // last stage (o_wb_data) changes solely when a read-hit ack is presented.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            if (accept_s && ack_in_s && rd_in_s) begin
                dat_q[0] <= mem_q[idx_s];
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (!flush_s && ack_q[k-1] && rd_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    // Byte-enabled memory write; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < SELW; b++) begin
                if (i_wb_sel[b]) begin
                    mem_q[idx_s][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_memresp_wb.sv
// Self-checking bench for memresp_wb: directed scenarios plus randomized traffic
// compared against a queue-of-pending-responses reference model.
module tb_memresp_wb;
    localparam int          LAT  = 2;
    localparam logic [29:0] BASE = 30'h4000000;
    localparam logic [29:0] MASK = 30'h4000000;
`ifdef MEMRESP_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [29:0] i_wb_addr = 30'h0;
    logic [31:0] i_wb_data = 32'h0;
    logic [3:0]  i_wb_sel = 4'h0;
    logic        o_wb_stall, o_wb_ack, o_wb_err;
    logic [31:0] o_wb_data;

    memresp_wb dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_wb_data(o_wb_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] mmem [4096];
    logic [31:0] fill_d [32];
    bit          errmode, exp_ack, exp_err, exp_stall;
    logic [31:0] exp_data;
    bit          pw_v;
    logic [11:0] pw_idx;
    logic [31:0] pw_dat;
    logic [3:0]  pw_sel;
    int          t = 0;
    int          checks = 0;
    int          passed = 0;

    task automatic model_reset();
        rq.delete();
        errmode   = 1'b0;
        exp_ack   = 1'b0;
        exp_err   = 1'b0;
        exp_stall = 1'b0;
        exp_data  = 32'h0;
        pw_v      = 1'b0;
    endtask

    // Responses due this cycle, then acceptance of the request on the inputs.
    task automatic model_begin();
        resp_t r;
        bit    hit;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (rq.size() > 0 && rq[0].due == t) begin
            exp_ack = !rq[0].err;
            exp_err = rq[0].err;
            if (exp_ack && rq[0].rd) exp_data = rq[0].data;
        end
        exp_stall = errmode || exp_err;
        if (i_wb_cyc && i_wb_stb && !exp_stall) begin
            hit    = ((i_wb_addr & MASK) == BASE);
            r.due  = t + LAT;
            r.err  = !hit || (i_wb_we && WRPROT);
            r.rd   = !i_wb_we;
            r.data = mmem[i_wb_addr[11:0]];
            rq.push_back(r);
            if (hit && i_wb_we && !WRPROT) begin
                pw_v   = 1'b1;
                pw_idx = i_wb_addr[11:0];
                pw_dat = i_wb_data;
                pw_sel = i_wb_sel;
            end
        end
    endtask

    task automatic model_end();
        if (pw_v) begin
            for (int b = 0; b < 4; b++)
                if (pw_sel[b]) mmem[pw_idx][8*b +: 8] = pw_dat[8*b +: 8];
            pw_v = 1'b0;
        end
        if (rq.size() > 0 && rq[0].due == t) void'(rq.pop_front());
        if (!i_wb_cyc) begin
            rq.delete();
            errmode = 1'b0;
        end else if (exp_err) begin
            rq.delete();
            errmode = 1'b1;
        end
    endtask

    task automatic tick();
        model_end();
        @(posedge i_clk);
        #1;
        t++;
    endtask

    task automatic apply(input logic c, input logic s, input logic w,
                         input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl);
        i_wb_cyc  = c;
        i_wb_stb  = s;
        i_wb_we   = w;
        i_wb_addr = a;
        i_wb_data = d;
        i_wb_sel  = sl;
        model_begin();
        #3;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000 || o_wb_data !== 32'h0)
            $display("FAIL reset_state got ack/err/stall=%b data=%h want 000 data=0",
                     {o_wb_ack, o_wb_err, o_wb_stall}, o_wb_data);
        else passed++;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        t = 0;
        model_reset();
        apply(1'b1, 1'b1, 1'b0, 30'h0000100, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b011)
            $display("FAIL first_accept got ack/err/stall=%b want 011", {o_wb_ack, o_wb_err, o_wb_stall});
        else passed++;
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic test_fill();
        logic [31:0] fd;
        for (int i = 0; i < 34; i++) begin
            tick();
            fd = $urandom;
            if (i < 32) begin
                fill_d[i] = fd;
                apply(1'b1, 1'b1, 1'b1, BASE | 30'(i), fd, 4'hF);
            end else begin
                apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
            end
            checks++;
            if ({o_wb_ack, o_wb_err, o_wb_stall} !== {exp_ack, exp_err, exp_stall} || (i >= 2 && o_wb_ack !== 1'b1))
                $display("FAIL fill_ack i=%0d got %b want %b", i,
                         {o_wb_ack, o_wb_err, o_wb_stall}, {exp_ack, exp_err, exp_stall});
            else passed++;
        end
    endtask

    task automatic test_write_read();
        tick(); apply(1'b1, 1'b1, 1'b1, 30'h4000010, 32'hDEADBEEF, 4'hF);
        tick(); apply(1'b1, 1'b1, 1'b0, 30'h4000010, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if (o_wb_ack !== 1'b1) $display("FAIL wr_ack got %b want 1", o_wb_ack);
        else passed++;
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if (o_wb_ack !== 1'b1 || o_wb_data !== 32'hDEADBEEF)
            $display("FAIL rd_full got ack=%b data=%h want 1 DEADBEEF", o_wb_ack, o_wb_data);
        else passed++;
        tick(); apply(1'b1, 1'b1, 1'b1, 30'h4000010, 32'h0000AA00, 4'b0010);
        tick(); apply(1'b1, 1'b1, 1'b0, 30'h4000010, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if (o_wb_ack !== 1'b1 || o_wb_data !== 32'hDEADAAEF)
            $display("FAIL rd_bytesel got ack=%b data=%h want 1 DEADAAEF", o_wb_ack, o_wb_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) apply(1'b1, 1'b1, 1'b0, BASE | 30'(k), 32'h0, 4'hF);
            else       apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
            checks++;
            if (o_wb_stall !== 1'b0 || o_wb_ack !== (k >= 2) ||
                (k >= 2 && o_wb_data !== fill_d[k-2]))
                $display("FAIL b2b k=%0d got stall=%b ack=%b data=%h want 0 %b %h",
                         k, o_wb_stall, o_wb_ack, o_wb_data, (k >= 2), (k >= 2) ? fill_d[k-2] : 32'h0);
            else passed++;
        end
    endtask

    task automatic test_miss();
        tick(); apply(1'b1, 1'b1, 1'b0, 30'h0000100, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000)
            $display("FAIL miss_c1 got %b want 000", {o_wb_ack, o_wb_err, o_wb_stall});
        else passed++;
        tick(); apply(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'hF);
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b011)
            $display("FAIL miss_err got %b want 011", {o_wb_ack, o_wb_err, o_wb_stall});
        else passed++;
        tick(); apply(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'hF);
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b001)
            $display("FAIL miss_hold got %b want 001", {o_wb_ack, o_wb_err, o_wb_stall});
        else passed++;
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if (o_wb_stall !== 1'b1) $display("FAIL miss_cyclow got stall=%b want 1", o_wb_stall);
        else passed++;
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000)
            $display("FAIL miss_release got %b want 000", {o_wb_ack, o_wb_err, o_wb_stall});
        else passed++;
    endtask

    task automatic test_cancel();
        tick(); apply(1'b1, 1'b1, 1'b0, BASE | 30'd1, 32'h0, 4'hF);
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
            checks++;
            if ({o_wb_ack, o_wb_err} !== 2'b00)
                $display("FAIL cancel k=%0d got ack/err=%b want 00", k, {o_wb_ack, o_wb_err});
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [29:0] a;
        bit          c, s, w;
        for (int n = 0; n < 600; n++) begin
            tick();
            c = ($urandom_range(0, 15) != 0);
            s = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 4);
            a = 30'($urandom);
            a[26] = ($urandom_range(0, 19) != 0);
            a[11:0] = 12'($urandom_range(0, 31));
            apply(c, s, w, a, $urandom, 4'($urandom));
            checks++;
            if ({o_wb_ack, o_wb_err, o_wb_stall} !== {exp_ack, exp_err, exp_stall} ||
                (o_wb_ack && o_wb_err))
                $display("FAIL rnd_resp n=%0d got ack/err/stall=%b want %b", n,
                         {o_wb_ack, o_wb_err, o_wb_stall}, {exp_ack, exp_err, exp_stall});
            else passed++;
            checks++;
            if (o_wb_data !== exp_data)
                $display("FAIL rnd_data n=%0d got %h want %h", n, o_wb_data, exp_data);
            else passed++;
        end
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        tick(); apply(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_midburst();
        tick(); apply(1'b1, 1'b1, 1'b0, BASE | 30'd2, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b1, 1'b0, BASE | 30'd3, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b1, 1'b1, BASE | 30'd2, 32'hCAFEF00D, 4'hF);
        checks++;
        if (o_wb_ack !== 1'b1 || o_wb_data !== exp_data)
            $display("FAIL pre_reset got ack=%b data=%h want 1 %h", o_wb_ack, o_wb_data, exp_data);
        else passed++;
        #1;
        i_reset  = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        #1;
        checks++;
        if ({o_wb_ack, o_wb_err, o_wb_stall} !== 3'b000 || o_wb_data !== 32'h0)
            $display("FAIL async_reset got ack/err/stall=%b data=%h want 000 0",
                     {o_wb_ack, o_wb_err, o_wb_stall}, o_wb_data);
        else passed++;
        model_reset();
        tick();
        i_reset = 1'b0;
        apply(1'b1, 1'b1, 1'b0, BASE | 30'd2, 32'h0, 4'hF);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        tick(); apply(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
        checks++;
        if (o_wb_ack !== 1'b1 || o_wb_data !== exp_data || o_wb_data === 32'hCAFEF00D)
            $display("FAIL drop_write got ack=%b data=%h want 1 %h", o_wb_ack, o_wb_data, exp_data);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_write_read();
        test_back_to_back();
        test_miss();
        test_cancel();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/memresp_wb.md
MEMRESP_WB -- requirements
Module: memresp_wb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 30, Wishbone word-address width (AW).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width (DW, multiple of 8).
REQ-003 SHALL have parameter MEM_ADDR, AW bits, default 30'h4000000, region base match value.
REQ-004 SHALL have parameter MEM_MASK, AW bits, default 30'h4000000, region match mask.
REQ-005 SHALL have parameter LGMEMSZ, default 12, log2 of memory depth in words.
REQ-006 SHALL have parameter LATENCY, default 2, accept-to-response cycles (legal range 1..8).
REQ-007 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports i_wb_cyc and i_wb_stb, input, 1 each, Wishbone B4 pipelined cycle and strobe.
REQ-010 SHALL have port i_wb_we, input, 1, write enable.
REQ-011 SHALL have port i_wb_addr, input, AW, word address.
REQ-012 SHALL have port i_wb_data, input, DW, write data.
REQ-013 SHALL have port i_wb_sel, input, DW/8, byte enables.
REQ-014 SHALL have port o_wb_stall, output, 1, request not accepted.
REQ-015 SHALL have ports o_wb_ack and o_wb_err, output, 1 each, response strobes.
REQ-016 SHALL have port o_wb_data, output, DW, read data.

Function
REQ-017 Request accepted when i_wb_cyc && i_wb_stb && !o_wb_stall; one per cycle max.
REQ-018 Hit: (i_wb_addr & MEM_MASK) == MEM_ADDR over full AW; else miss.
REQ-019 Memory index = i_wb_addr[LGMEMSZ-1:0]; higher hit-address bits alias (wrap modulo 2^LGMEMSZ).
REQ-020 Hit write: bytes with i_wb_sel set written in the cycle after accept; unselected bytes unchanged; o_wb_ack exactly LATENCY cycles after accept.
REQ-021 Hit read: o_wb_ack with memory word in o_wb_data exactly LATENCY cycles after accept; read-after-write to same index returns new data if issued in a later cycle.
REQ-022 Miss: no memory access; o_wb_err exactly LATENCY cycles after accept, o_wb_ack low.
REQ-023 o_wb_data updates only on read-hit acks; holds otherwise.
REQ-024 Responses in acceptance order; back-to-back accepts yield back-to-back responses; o_wb_ack and o_wb_err never both high.
REQ-025 Error state: from cycle o_wb_err asserts, o_wb_stall=1, all later in-flight responses discarded, until i_wb_cyc low.
REQ-026 o_wb_stall=0 outside error state.
REQ-027 i_wb_cyc low: every in-flight response cancelled (no ack/err from that cycle on); accepted writes still commit.
REQ-028 Request accepted same cycle a response is issued: both proceed independently.

Reset
REQ-029 i_reset asynchronously forces o_wb_ack=0, o_wb_err=0, o_wb_stall=0, o_wb_data=0, clears response pipeline and error state.
REQ-030 Memory contents not reset; write pending at reset is dropped.
REQ-031 First acceptance possible on first rising edge after i_reset deasserts.

Configuration
REQ-032 Macro MEMRESP_WRPROT_EN defined: hit writes do not modify memory and return o_wb_err after LATENCY (region read-only); hit reads unchanged.
REQ-033 Macro undefined: hit writes behave per REQ-020.

Verification (MEM_ADDR=MEM_MASK=30'h4000000, LGMEMSZ=12, LATENCY=2)
REQ-034 Write 30'h4000010, data 32'hDEADBEEF, sel 4'hF, then read 30'h4000010 -> ack 2 cycles after each accept, read data 32'hDEADBEEF.
REQ-035 Then write 32'h0000AA00 sel 4'b0010 to same address, read -> 32'hDEADAAEF.
REQ-036 Four consecutive reads 30'h4000000..30'h4000003 accepted cycles 0..3 -> acks cycles 2..5, data in order, o_wb_stall always 0.
REQ-037 Read 30'h0000100 (miss) -> o_wb_err cycle 2, no ack, o_wb_stall high until cyc drops, then low next cycle.
REQ-038 Read accepted cycle 0, i_wb_cyc low cycle 1 -> no ack; i_reset asserted mid-burst -> ack/err low immediately, before next edge.
REQ-039 With MEMRESP_WRPROT_EN: write 32'h12345678 to 30'h4000020 -> err cycle 2; subsequent read returns prior contents.
